// File: rtl/dft_accumulation_tdm_if.sv
// Sample-stream and result-stream bundle for the time-multiplexed DFT accumulator.
// The slave modport is the accumulator's view; the master modport is the source/sink side.
interface dft_accumulation_tdm_if #(
  parameter int unsigned IQ_WIDTH     = 16,
  parameter int unsigned WINDOW_WIDTH = 18,
  parameter int unsigned ACCUM_WIDTH  = 48,
  parameter int unsigned MAX_BINS     = 16,
  parameter int unsigned BW           = $clog2(MAX_BINS + 1)
);
  logic                           s_valid_i;
  logic                           s_ready_o;
  logic                           s_last_i;
  logic signed [IQ_WIDTH-1:0]     i_sample_i;
  logic signed [IQ_WIDTH-1:0]     q_sample_i;
  logic signed [WINDOW_WIDTH-1:0] window_coeff_i;

  logic                           res_valid_o;
  logic                           res_ready_i;
  logic [BW-1:0]                  res_bin_o;
  logic signed [ACCUM_WIDTH-1:0]  res_real_o;
  logic signed [ACCUM_WIDTH-1:0]  res_imag_o;
  logic                           res_last_o;

  modport master (
    output s_valid_i, s_last_i, i_sample_i, q_sample_i, window_coeff_i, res_ready_i,
    input  s_ready_o, res_valid_o, res_bin_o, res_real_o, res_imag_o, res_last_o
  );

  modport slave (
    input  s_valid_i, s_last_i, i_sample_i, q_sample_i, window_coeff_i, res_ready_i,
    output s_ready_o, res_valid_o, res_bin_o, res_real_o, res_imag_o, res_last_o
  );
endinterface

// File: rtl/dft_accumulation_tdm.sv
// Windowed multi-bin DFT accumulator: one complex MAC engine shared by all bins,
// one bin per cycle, with per-bin recursive oscillators W[k] <= W[k]*E[k].
module dft_accumulation_tdm #(
  parameter int unsigned IQ_WIDTH           = 16,
  parameter int unsigned WINDOW_WIDTH       = 18,
  parameter int unsigned OSC_WIDTH          = 18,
  parameter int unsigned ACCUM_WIDTH        = 48,
  parameter int unsigned MAX_BINS           = 16,
  parameter int unsigned SAMPLE_COUNT_WIDTH = 16,
  parameter int unsigned BW                 = $clog2(MAX_BINS + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic                                 abort_i,
  input  logic [BW-1:0]                        num_bins_i,
  input  logic signed [OSC_WIDTH-1:0]          E_real_i [MAX_BINS],
  input  logic signed [OSC_WIDTH-1:0]          E_imag_i [MAX_BINS],
  dft_accumulation_tdm_if.slave                bus,
  output logic                                 sat_o,
  output logic                                 busy_o,
  output logic [SAMPLE_COUNT_WIDTH-1:0]        sample_count_o
);

  localparam int unsigned XW   = IQ_WIDTH + WINDOW_WIDTH;
  localparam int unsigned PW   = XW + OSC_WIDTH + 1;
  localparam int unsigned WPW  = 2 * OSC_WIDTH + 1;
  localparam int unsigned SH   = OSC_WIDTH - 2;
  localparam int unsigned SUMW = ((ACCUM_WIDTH > PW) ? ACCUM_WIDTH : PW) + 1;
  localparam int unsigned IW   = (MAX_BINS > 1) ? $clog2(MAX_BINS) : 1;

  localparam logic signed [ACCUM_WIDTH-1:0] ACC_MAX = {1'b0, {(ACCUM_WIDTH-1){1'b1}}};
  localparam logic signed [ACCUM_WIDTH-1:0] ACC_MIN = {1'b1, {(ACCUM_WIDTH-1){1'b0}}};
  localparam logic signed [OSC_WIDTH-1:0]   W_ONE   = {2'b01, {(OSC_WIDTH-2){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PROC, S_OUT} state_t;

  state_t                         state_q;
  logic [BW-1:0]                  n_q;
  logic [BW-1:0]                  bin_q;
  logic signed [IQ_WIDTH-1:0]     i_q;
  logic signed [IQ_WIDTH-1:0]     q_q;
  logic signed [WINDOW_WIDTH-1:0] h_q;
  logic                           last_q;
  logic signed [ACCUM_WIDTH-1:0]  acc_re [MAX_BINS];
  logic signed [ACCUM_WIDTH-1:0]  acc_im [MAX_BINS];
  logic signed [OSC_WIDTH-1:0]    w_re   [MAX_BINS];
  logic signed [OSC_WIDTH-1:0]    w_im   [MAX_BINS];

  logic                           s_ready_q;
  logic                           res_valid_q;
  logic [BW-1:0]                  res_bin_q;
  logic signed [ACCUM_WIDTH-1:0]  res_re_q;
  logic signed [ACCUM_WIDTH-1:0]  res_im_q;
  logic                           res_last_q;
  logic                           sat_q;
  logic                           busy_q;
  logic [SAMPLE_COUNT_WIDTH-1:0]  count_q;

  logic [IW-1:0]                  idx;
  logic [BW-1:0]                  bin_nx;
  logic [BW-1:0]                  n_m1;
  logic [BW-1:0]                  n_eff;
  logic                           last_bin;
  logic signed [XW-1:0]           xr, xi;
  logic signed [PW-1:0]           pr, pi, cr, ci;
  logic signed [SUMW-1:0]         sum_re, sum_im;
  logic signed [ACCUM_WIDTH-1:0]  nxt_re, nxt_im;
  logic                           clip;
  logic signed [WPW-1:0]          wp_re, wp_im;
  logic signed [OSC_WIDTH-1:0]    nw_re, nw_im;
  logic signed [ACCUM_WIDTH-1:0]  first_re, first_im;

  // Shared MAC datapath for the bin currently addressed by bin_q
  always_comb begin
    idx      = bin_q[IW-1:0];
    bin_nx   = bin_q + BW'(1);
    n_m1     = n_q - BW'(1);
    last_bin = (bin_q == n_m1);
    n_eff    = ((num_bins_i == '0) || (num_bins_i > BW'(MAX_BINS))) ? BW'(MAX_BINS) : num_bins_i;

    xr = XW'(i_q) * XW'(h_q);
    xi = XW'(q_q) * XW'(h_q);
    pr = PW'(xr) * PW'(w_re[idx]) - PW'(xi) * PW'(w_im[idx]);
    pi = PW'(xr) * PW'(w_im[idx]) + PW'(xi) * PW'(w_re[idx]);
    cr = pr >>> SH;
    ci = pi >>> SH;

    sum_re = SUMW'(acc_re[idx]) + SUMW'(cr);
    sum_im = SUMW'(acc_im[idx]) + SUMW'(ci);
    clip   = 1'b0;
    nxt_re = ACCUM_WIDTH'(sum_re);
    nxt_im = ACCUM_WIDTH'(sum_im);
    if (sum_re > SUMW'(ACC_MAX)) begin
      nxt_re = ACC_MAX;
      clip   = 1'b1;
    end else if (sum_re < SUMW'(ACC_MIN)) begin
      nxt_re = ACC_MIN;
      clip   = 1'b1;
    end
    if (sum_im > SUMW'(ACC_MAX)) begin
      nxt_im = ACC_MAX;
      clip   = 1'b1;
    end else if (sum_im < SUMW'(ACC_MIN)) begin
      nxt_im = ACC_MIN;
      clip   = 1'b1;
    end

    // Oscillator step wraps on overflow by design
    wp_re = WPW'(w_re[idx]) * WPW'(E_real_i[idx]) - WPW'(w_im[idx]) * WPW'(E_imag_i[idx]);
    wp_im = WPW'(w_re[idx]) * WPW'(E_imag_i[idx]) + WPW'(w_im[idx]) * WPW'(E_real_i[idx]);
    nw_re = OSC_WIDTH'(wp_re >>> SH);
    nw_im = OSC_WIDTH'(wp_im >>> SH);

    // Bin 0 result forwarded when it is being written in the same cycle (N=1)
    first_re = (idx == '0) ? nxt_re : acc_re[0];
    first_im = (idx == '0) ? nxt_im : acc_im[0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      bin_q       <= '0;
      i_q         <= '0;
      q_q         <= '0;
      h_q         <= '0;
      last_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_bin_q   <= '0;
      res_re_q    <= '0;
      res_im_q    <= '0;
      res_last_q  <= 1'b0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
      count_q     <= '0;
      for (int k = 0; k < int'(MAX_BINS); k++) begin
        acc_re[k] <= '0;
        acc_im[k] <= '0;
        w_re[k]   <= '0;
        w_im[k]   <= '0;
      end
    end else if ((state_q != S_IDLE) && abort_i) begin
      state_q     <= S_IDLE;
      s_ready_q   <= 1'b0;
      res_valid_q <= 1'b0;
      res_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            n_q       <= n_eff;
            bin_q     <= '0;
            count_q   <= '0;
            sat_q     <= 1'b0;
            s_ready_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_WAIT;
            for (int k = 0; k < int'(MAX_BINS); k++) begin
              acc_re[k] <= '0;
              acc_im[k] <= '0;
              w_re[k]   <= W_ONE;
              w_im[k]   <= '0;
            end
          end
        end
        S_WAIT: begin
          if (bus.s_valid_i && s_ready_q) begin
            i_q       <= bus.i_sample_i;
            q_q       <= bus.q_sample_i;
            h_q       <= bus.window_coeff_i;
            last_q    <= bus.s_last_i;
            count_q   <= count_q + SAMPLE_COUNT_WIDTH'(1);
            bin_q     <= '0;
            s_ready_q <= 1'b0;
            state_q   <= S_PROC;
          end
        end
        S_PROC: begin
          acc_re[idx] <= nxt_re;
          acc_im[idx] <= nxt_im;
          w_re[idx]   <= nw_re;
          w_im[idx]   <= nw_im;
          if (clip) sat_q <= 1'b1;
          if (!last_bin) begin
            bin_q <= bin_nx;
          end else if (last_q) begin
            bin_q       <= '0;
            res_valid_q <= 1'b1;
            res_bin_q   <= '0;
            res_re_q    <= first_re;
            res_im_q    <= first_im;
            res_last_q  <= (n_q == BW'(1));
            state_q     <= S_OUT;
          end else begin
            s_ready_q <= 1'b1;
            state_q   <= S_WAIT;
          end
        end
        S_OUT: begin
          if (res_valid_q && bus.res_ready_i) begin
            if (res_last_q) begin
              res_valid_q <= 1'b0;
              res_last_q  <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= S_IDLE;
            end else begin
              bin_q      <= bin_nx;
              res_bin_q  <= bin_nx;
              res_re_q   <= acc_re[bin_nx[IW-1:0]];
              res_im_q   <= acc_im[bin_nx[IW-1:0]];
              res_last_q <= (bin_nx == n_m1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.s_ready_o   = s_ready_q;
  assign bus.res_valid_o = res_valid_q;
  assign bus.res_bin_o   = res_bin_q;
  assign bus.res_real_o  = res_re_q;
  assign bus.res_imag_o  = res_im_q;
  assign bus.res_last_o  = res_last_q;
  assign sat_o           = sat_q;
  assign busy_o          = busy_q;
  assign sample_count_o  = count_q;

endmodule

// File: tb/tb_dft_accumulation_tdm.sv
// Randomised bench for dft_accumulation_tdm against a plain-arithmetic DFT model,
// plus hand-computed frames for the documented corner cases.
module tb_dft_accumulation_tdm;
  localparam int IQW = 16;
  localparam int WW  = 18;
  localparam int OW  = 18;
  localparam int AW  = 24;
  localparam int MB  = 16;
  localparam int SCW = 16;
  localparam int BW  = 5;
  localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
  localparam longint AMIN = -(longint'(1) << (AW - 1));

  logic clk = 1'b0;
  logic rst;
  logic start, abort;
  logic [BW-1:0] num_bins;
  logic signed [OW-1:0] e_re [MB];
  logic signed [OW-1:0] e_im [MB];
  logic sat, busy;
  logic [SCW-1:0] scount;

  always #5 clk = ~clk;

  dft_accumulation_tdm_if #(.IQ_WIDTH(IQW), .WINDOW_WIDTH(WW), .ACCUM_WIDTH(AW),
                            .MAX_BINS(MB), .BW(BW)) bus ();

  dft_accumulation_tdm #(
    .IQ_WIDTH(IQW), .WINDOW_WIDTH(WW), .OSC_WIDTH(OW), .ACCUM_WIDTH(AW),
    .MAX_BINS(MB), .SAMPLE_COUNT_WIDTH(SCW), .BW(BW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .num_bins_i(num_bins), .E_real_i(e_re), .E_imag_i(e_im),
    .bus(bus), .sat_o(sat), .busy_o(busy), .sample_count_o(scount)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int     bin;
    longint re;
    longint im;
    bit     last;
  } res_t;
  res_t exp_q[$];

  longint got_re [MB];
  longint got_im [MB];
  int     got_cnt;
  bit     hold_ready = 1'b0;

  longint m_re [MB];
  longint m_im [MB];
  longint m_wr [MB];
  longint m_wi [MB];
  int     m_n;
  bit     m_sat;
  int     m_cnt;

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic fail_timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  function automatic longint trunc_osc(longint v);
    longint t;
    t = v <<< (64 - OW);
    return t >>> (64 - OW);
  endfunction

  function automatic longint clamp(longint v, inout bit s);
    if (v > AMAX) begin s = 1'b1; return AMAX; end
    if (v < AMIN) begin s = 1'b1; return AMIN; end
    return v;
  endfunction

  function automatic void model_init(int n);
    m_n = (n == 0 || n > MB) ? MB : n;
    for (int k = 0; k < MB; k++) begin
      m_re[k] = 0; m_im[k] = 0; m_wr[k] = 65536; m_wi[k] = 0;
    end
    m_sat = 1'b0;
    m_cnt = 0;
  endfunction

  // Direct DFT recurrence: A += (x*h)*W, W *= E, both in Q1.16 with floor shift
  function automatic void model_sample(int i, int q, int h);
    longint xr, xi, pr, pi, er, ei, nwr, nwi;
    xr = longint'(i) * longint'(h);
    xi = longint'(q) * longint'(h);
    for (int k = 0; k < m_n; k++) begin
      pr = xr * m_wr[k] - xi * m_wi[k];
      pi = xr * m_wi[k] + xi * m_wr[k];
      m_re[k] = clamp(m_re[k] + (pr >>> 16), m_sat);
      m_im[k] = clamp(m_im[k] + (pi >>> 16), m_sat);
      er = longint'(e_re[k]);
      ei = longint'(e_im[k]);
      nwr = trunc_osc((m_wr[k] * er - m_wi[k] * ei) >>> 16);
      nwi = trunc_osc((m_wr[k] * ei + m_wi[k] * er) >>> 16);
      m_wr[k] = nwr;
      m_wi[k] = nwi;
    end
    m_cnt++;
  endfunction

  function automatic void model_emit();
    res_t r;
    for (int k = 0; k < m_n; k++) begin
      r.bin = k; r.re = m_re[k]; r.im = m_im[k]; r.last = (k == m_n - 1);
      exp_q.push_back(r);
    end
  endfunction

  // Result checker: every valid cycle must present the next expected bin
  always @(negedge clk) begin
    if (!rst && bus.res_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: actual bin=%0d required=none", bus.res_bin_o);
      end else begin
        check("res_bin", longint'(bus.res_bin_o), longint'(exp_q[0].bin));
        check("res_real", longint'(bus.res_real_o), exp_q[0].re);
        check("res_imag", longint'(bus.res_imag_o), exp_q[0].im);
        check("res_last", longint'(bus.res_last_o), longint'(exp_q[0].last));
        if (bus.res_ready_i) begin
          if (int'(bus.res_bin_o) < MB) begin
            got_re[bus.res_bin_o[3:0]] = longint'(bus.res_real_o);
            got_im[bus.res_bin_o[3:0]] = longint'(bus.res_imag_o);
          end
          got_cnt++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.res_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.res_ready_i = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_frame(int n);
    start = 1'b1;
    num_bins = BW'(n);
    tick();
    start = 1'b0;
    model_init(n);
    got_cnt = 0;
    for (int k = 0; k < MB; k++) begin got_re[k] = -1; got_im[k] = -1; end
  endtask

  task automatic send_sample(int i, int q, int h, bit last);
    bit ok = 1'b0;
    bus.s_valid_i = 1'b1;
    bus.i_sample_i = IQW'(i);
    bus.q_sample_i = IQW'(q);
    bus.window_coeff_i = WW'(h);
    bus.s_last_i = last;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (bus.s_ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      bus.s_valid_i = 1'b0;
      fail_timeout("sample_accept");
      return;
    end
    @(posedge clk); #1;
    bus.s_valid_i = 1'b0;
    model_sample(i, q, h);
    if (last) model_emit();
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("frame_done");
    check("results_drained", longint'(exp_q.size()), 0);
    check("sample_count", longint'(scount), longint'(m_cnt & 16'hFFFF));
    check("sat", longint'(sat), longint'(m_sat));
  endtask

  task automatic rand_frame();
    int n, ns, amp, hamp, v;
    n = $urandom_range(0, 31);
    for (int k = 0; k < MB; k++) begin
      v = $urandom_range(0, 92000); e_re[k] = OW'(v - 46000);
      v = $urandom_range(0, 92000); e_im[k] = OW'(v - 46000);
    end
    amp  = ($urandom_range(0, 3) == 0) ? 32767 : 2000;
    hamp = ($urandom_range(0, 3) == 0) ? 131071 : 3000;
    ns = $urandom_range(1, 8);
    start_frame(n);
    for (int s = 0; s < ns; s++) begin
      int i, q, h;
      v = $urandom_range(0, 2 * amp);  i = v - amp;
      v = $urandom_range(0, 2 * amp);  q = v - amp;
      v = $urandom_range(0, 2 * hamp); h = v - hamp;
      send_sample(i, q, h, s == ns - 1);
      repeat ($urandom_range(0, 2)) tick();
    end
    wait_idle();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowc, hb, hr;
    bit ok;
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_bins = '0;
    bus.s_valid_i = 1'b0; bus.s_last_i = 1'b0;
    bus.i_sample_i = '0; bus.q_sample_i = '0; bus.window_coeff_i = '0;
    for (int k = 0; k < MB; k++) begin e_re[k] = '0; e_im[k] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_s_ready", longint'(bus.s_ready_o), 0);
    check("rst_res_valid", longint'(bus.res_valid_o), 0);
    check("rst_sat", longint'(sat), 0);
    check("rst_count", longint'(scount), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // N=1, unit rotation, three samples of 100
    e_re[0] = OW'(65536); e_im[0] = '0;
    start_frame(1);
    for (int s = 0; s < 3; s++) send_sample(100, 0, 1, s == 2);
    wait_idle();
    check("n1_real", got_re[0], 300);
    check("n1_imag", got_im[0], 0);
    check("n1_count", longint'(scount), 3);
    check("n1_results", longint'(got_cnt), 1);

    // N=4 single sample: 4 processing cycles, back-pressured output
    for (int k = 0; k < 4; k++) begin e_re[k] = OW'(65536); e_im[k] = '0; end
    hold_ready = 1'b1;
    start_frame(4);
    send_sample(10, 0, 1, 1'b1);
    lowc = 0; ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.res_valid_o) begin ok = 1'b1; break; end
      if (!bus.s_ready_o) lowc++;
    end
    if (!ok) fail_timeout("n4_first_result");
    check("n4_proc_cycles", longint'(lowc), 4);
    hb = int'(bus.res_bin_o); hr = int'(bus.res_real_o);
    repeat (5) @(negedge clk);
    check("hold_bin", longint'(bus.res_bin_o), longint'(hb));
    check("hold_real", longint'(bus.res_real_o), longint'(hr));
    check("hold_valid", longint'(bus.res_valid_o), 1);
    hold_ready = 1'b0;
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      check("n4_real", got_re[k], 10);
      check("n4_imag", got_im[k], 0);
    end
    check("n4_results", longint'(got_cnt), 4);

    // +90 degree rotation: four quarter turns cancel
    e_re[0] = '0; e_im[0] = OW'(65536);
    start_frame(1);
    for (int s = 0; s < 4; s++) send_sample(1000, 0, 1, s == 3);
    wait_idle();
    check("rot_real", got_re[0], 0);
    check("rot_imag", got_im[0], 0);

    // Saturation at 24 bits
    e_re[0] = OW'(65536); e_im[0] = '0;
    start_frame(1);
    for (int s = 0; s < 200; s++) send_sample(32767, 32767, 131071, s == 199);
    wait_idle();
    check("sat_real", got_re[0], 8388607);
    check("sat_imag", got_im[0], 8388607);
    check("sat_flag", longint'(sat), 1);

    repeat (6) rand_frame();

    // Abort while processing
    start_frame(8);
    send_sample(500, -300, 7, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_busy", longint'(busy), 0);
    check("abort_s_ready", longint'(bus.s_ready_o), 0);
    repeat (10) tick();
    rand_frame();

    // Reset pulse during output
    hold_ready = 1'b1;
    start_frame(3);
    send_sample(1234, 567, 89, 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.res_valid_o) begin ok = 1'b1; break; end
    end
    if (!ok) fail_timeout("rst_out_result");
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_out_busy", longint'(busy), 0);
    check("rst_out_valid", longint'(bus.res_valid_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold_ready = 1'b0;
    repeat (8) @(negedge clk);
    check("post_rst_valid", longint'(bus.res_valid_o), 0);
    tick();

    e_re[0] = OW'(65536); e_im[0] = '0;
    start_frame(1);
    for (int s = 0; s < 3; s++) send_sample(100, 0, 1, s == 2);
    wait_idle();
    check("after_rst_real", got_re[0], 300);

    repeat (6) rand_frame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
